// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared FSM state type and timing constants for the AES-128 round sequencer
package aes_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, DONE = 2'd3} aes_state_e;
  localparam int AES_LOAD_CYCLES = 16;
  localparam int AES_ROUND_CYCLES = 20;
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_CNT_W = 5;
  localparam int AES_RND_W = 4;
endpackage

// File: rtl/aes_phase_counter.sv
// aes_phase_counter: wrapping counter (clr/en in, cnt/tc out) that rolls to 0 after reaching term
module aes_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == term_i;
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: IDLE/LOAD/ROUND/DONE sequencer (start/abort/out_ready in; phase, round and handshake controls out)
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES = AES_LOAD_CYCLES,
  parameter int ROUND_CYCLES = AES_ROUND_CYCLES,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 load_en,
  output logic [AES_CNT_W-1:0] state_counter,
  output logic [AES_RND_W-1:0] round_num,
  output logic                 rcon_en,
  output logic                 round_end,
  output logic                 mix_en,
  output logic                 last_round,
  output logic                 out_valid
);
  localparam logic [AES_CNT_W-1:0] LOAD_TC = AES_CNT_W'(LOAD_CYCLES - 1);
  localparam logic [AES_CNT_W-1:0] ROUND_TC = AES_CNT_W'(ROUND_CYCLES - 1);
  localparam logic [AES_RND_W-1:0] LAST_RND = AES_RND_W'(NUM_ROUNDS);
  if (LOAD_CYCLES > 32 || ROUND_CYCLES > 32) begin : g_bad_cfg
    $error("phase length exceeds state_counter range");
  end
  aes_state_e state_q, state_d;
  logic [AES_RND_W-1:0] round_q, round_d;
  logic [AES_CNT_W-1:0] cnt;
  logic tc, in_load, in_round, is_last;
  assign in_load = state_q == LOAD;
  assign in_round = state_q == ROUND;
  assign is_last = round_q == LAST_RND;
  aes_phase_counter #(.W(AES_CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (abort || state_q == IDLE || state_q == DONE),
    .en_i   (in_load || in_round),
    .term_i (in_load ? LOAD_TC : ROUND_TC),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    if (abort) begin
      state_d = IDLE;
      round_d = '0;
    end else if (state_q == IDLE && start) state_d = LOAD;
    else if (in_load && tc) begin
      state_d = ROUND;
      round_d = AES_RND_W'(1);
    end else if (in_round && tc) begin
      state_d = is_last ? DONE : ROUND;
      round_d = is_last ? '0 : round_q + AES_RND_W'(1);
    end else if (state_q == DONE && out_ready) state_d = start ? LOAD : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  assign busy = state_q != IDLE;
  assign load_en = in_load;
  assign state_counter = cnt;
  assign round_num = round_q;
  assign rcon_en = in_round;
  assign round_end = in_round && cnt == ROUND_TC;
  assign mix_en = in_round && !is_last;
  assign last_round = in_round && is_last;
  assign out_valid = state_q == DONE;
  a_round_range: assert property (@(posedge clk) disable iff (rst) round_q <= LAST_RND);
endmodule
